// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round/schedule helper functions.
package sha256_pkg;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
    typedef logic [0:7][31:0] hstate_t;

    localparam hstate_t SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam hstate_t SHA224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: {a..h}, K[t], W[t} -> {a'..h'}; a is the top word.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_i,
    input  logic [31:0]  k_i,
    input  logic [31:0]  w_i,
    output logic [255:0] st_o
);
    hstate_t     s;
    logic [31:0] t1, t2;

    assign s  = st_i;
    assign t1 = s[7] + Sigma1(s[4]) + ch(s[4], s[5], s[6]) + k_i + w_i;
    assign t2 = Sigma0(s[0]) + maj(s[0], s[1], s[2]);
    assign st_o = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock, chaining across blocks.
// Optional SHA224_MODE_EN adds a mode224 input selecting the SHA-224 IV and truncated digest.
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
`ifdef SHA224_MODE_EN
    input  logic         mode224,
`endif
    input  logic [511:0] block_in,
    input  logic         block_valid,
    input  logic         block_first,
    input  logic         block_last,
    output logic         block_ready,
    output logic [255:0] digest_out,
    output logic         digest_valid,
    output logic         busy
);
    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_r
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t            state_q;
    logic [5:0]        ctr_q;
    logic              last_q, ready_q, busy_q, dvalid_q;
    hstate_t           h_q, v_q, h_d, v_d;
    logic [0:15][31:0] w_q, w_d;
    logic [255:0]      digest_q;
    logic [6:0]        ctr_nxt;
    logic              accept, mode_cur, mode_new;
    hstate_t           iv_cur, iv_new;

    assign accept  = block_valid & ready_q;
    assign ctr_nxt = {1'b0, ctr_q} + 7'(R);

`ifdef SHA224_MODE_EN
    logic mode_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   mode_q <= 1'b0;
        else if (accept && block_first) mode_q <= mode224;
    end
    assign mode_cur = mode_q;
    assign mode_new = block_first ? mode224 : mode_q;
`else
    assign mode_cur = 1'b0;
    assign mode_new = 1'b0;
`endif

    assign iv_cur = mode_cur ? SHA224_IV : SHA256_IV;
    assign iv_new = mode_new ? SHA224_IV : SHA256_IV;

    // Round chain plus the R new schedule words; later words feed on earlier ones of this cycle.
    for (genvar j = 0; j < R; j++) begin : g_rnd
        logic [255:0] st_in, st_out;
        logic [5:0]   kidx;
        logic [31:0]  wnew;

        assign kidx = ctr_q + 6'(j);
        if (j == 0) begin : g_head
            assign st_in = v_q;
        end else begin : g_link
            assign st_in = g_rnd[j-1].st_out;
        end

        sha256_round u_round (.st_i(st_in), .k_i(K[kidx]), .w_i(w_q[j]), .st_o(st_out));

        if (j < 2) begin : g_w0
            assign wnew = sigma1(w_q[14+j]) + w_q[9+j] + sigma0(w_q[1+j]) + w_q[j];
        end else if (j < 7) begin : g_w1
            assign wnew = sigma1(g_rnd[j-2].wnew) + w_q[9+j] + sigma0(w_q[1+j]) + w_q[j];
        end else begin : g_w2
            assign wnew = sigma1(g_rnd[j-2].wnew) + g_rnd[j-7].wnew + sigma0(w_q[1+j]) + w_q[j];
        end
    end
    assign v_d = g_rnd[R-1].st_out;

    for (genvar i = 0; i < 16; i++) begin : g_wsh
        if (i + R < 16) begin : g_keep
            assign w_d[i] = w_q[i+R];
        end else begin : g_new
            assign w_d[i] = g_rnd[i+R-16].wnew;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_hadd
        assign h_d[i] = h_q[i] + v_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ctr_q    <= '0;
            last_q   <= 1'b0;
            h_q      <= SHA256_IV;
            v_q      <= '0;
            w_q      <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            dvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        w_q     <= block_in;
                        v_q     <= block_first ? iv_new : h_q;
                        if (block_first) h_q <= iv_new;
                        last_q  <= block_last;
                        ctr_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    v_q   <= v_d;
                    w_q   <= w_d;
                    ctr_q <= ctr_nxt[5:0];
                    if (ctr_nxt == 7'd64) state_q <= FINAL;
                end
                FINAL: begin
                    h_q <= last_q ? iv_cur : h_d;
                    if (last_q) begin
                        digest_q <= mode_cur ? {h_d[0:6], 32'h0} : h_d;
                        dvalid_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign block_ready  = ready_q;
    assign busy         = busy_q;
    assign digest_out   = digest_q;
    assign digest_valid = dvalid_q;
endmodule
